// File: rtl/needs_scheduler.sv
// Pet need-register owner: schedules 1 Hz decay/life-adjust passes and user
// action requests onto food/fun/rest/life/medicines, with cooldowns and death.
module needs_scheduler #(
  parameter int unsigned MAX_VAL    = 100,
  parameter int unsigned INIT_LIFE  = 100,
  parameter int unsigned INIT_NEED  = 50,
  parameter int unsigned FOOD_DIV   = 3,
  parameter int unsigned FUN_DIV    = 4,
  parameter int unsigned REST_DIV   = 5,
  parameter int unsigned LIFE_PLUS  = 70,
  parameter int unsigned LIFE_MINUS = 30,
  parameter int unsigned DISEASE_TH = 20,
  parameter int unsigned ACT_STEP   = 5,
  parameter int unsigned HEAL_AMT   = 20,
  parameter int unsigned COOLDOWN   = 3,
  parameter int unsigned MED_MAX    = 9
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       tick,
  input  logic       req_valid,
  input  logic [1:0] req_kind,
  output logic       req_ready,
  output logic       resp_valid,
  output logic [1:0] resp_status,
  input  logic       med_add,
  output logic [6:0] food,
  output logic [6:0] fun,
  output logic [6:0] rest,
  output logic [6:0] life,
  output logic [3:0] medicines,
  output logic       disease,
  output logic       death,
  output logic       tick_overrun
);

  localparam int unsigned VW = 7;
  localparam int unsigned AW = 8;
  localparam int unsigned MW = 4;
  localparam int unsigned DIV_MAX = (FOOD_DIV > FUN_DIV) ?
                                    ((FOOD_DIV > REST_DIV) ? FOOD_DIV : REST_DIV) :
                                    ((FUN_DIV > REST_DIV) ? FUN_DIV : REST_DIV);
  localparam int unsigned DW  = $clog2(DIV_MAX + 1);
  localparam int unsigned CDW = $clog2(COOLDOWN + 1);

  localparam logic [1:0] K_PLAY  = 2'd0;
  localparam logic [1:0] K_SLEEP = 2'd1;
  localparam logic [1:0] K_EAT   = 2'd2;
  localparam logic [1:0] K_HEAL  = 2'd3;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_COOL   = 2'd1;
  localparam logic [1:0] ST_NO_MED = 2'd2;
  localparam logic [1:0] ST_DEAD   = 2'd3;

  typedef enum logic [2:0] {IDLE, DECAY, LIFE_ADJ, ACTION, RESP} state_t;

  state_t                  state_q, state_d;
  logic [VW-1:0]           food_q, food_d, fun_q, fun_d, rest_q, rest_d, life_q, life_d;
  logic [MW-1:0]           med_q, med_d;
  logic [DW-1:0]           food_cnt_q, food_cnt_d, fun_cnt_q, fun_cnt_d, rest_cnt_q, rest_cnt_d;
  logic [3:0][CDW-1:0]     cd_q, cd_d;
  logic [1:0]              kind_q, kind_d;
  logic                    tick_pend_q, tick_pend_d;
  logic                    death_q, death_d;
  logic                    overrun_q, overrun_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [1:0]              resp_status_q, resp_status_d;
  logic                    enter_decay, med_inc, med_dec;
  logic [1:0]              n_plus, n_minus;
  logic [AW-1:0]           life_sum, life_new;

  function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] v, input logic [AW-1:0] amt);
    logic [AW-1:0] s;
    s = AW'(v) + amt;
    return (s > AW'(MAX_VAL)) ? VW'(MAX_VAL) : VW'(s);
  endfunction

  function automatic logic [VW-1:0] dec_sat(input logic [VW-1:0] v);
    return (v == '0) ? v : v - VW'(1);
  endfunction

  assign req_ready    = (state_q == IDLE) & ~tick_pend_q & ~tick;
  assign resp_valid   = resp_valid_q;
  assign resp_status  = resp_status_q;
  assign food         = food_q;
  assign fun          = fun_q;
  assign rest         = rest_q;
  assign life         = life_q;
  assign medicines    = med_q;
  assign death        = death_q;
  assign tick_overrun = overrun_q;
  assign disease      = (life_q <= VW'(DISEASE_TH)) & ~death_q;

  // Next-state and datapath for every register
  always_comb begin
    state_d       = state_q;
    food_d        = food_q;
    fun_d         = fun_q;
    rest_d        = rest_q;
    life_d        = life_q;
    med_d         = med_q;
    food_cnt_d    = food_cnt_q;
    fun_cnt_d     = fun_cnt_q;
    rest_cnt_d    = rest_cnt_q;
    cd_d          = cd_q;
    kind_d        = kind_q;
    death_d       = death_q;
    resp_valid_d  = 1'b0;
    resp_status_d = resp_status_q;
    enter_decay   = 1'b0;
    med_inc       = med_add & ~death_q;
    med_dec       = 1'b0;
    overrun_d     = overrun_q | (tick & tick_pend_q);

    n_plus   = 2'(food_q >= VW'(LIFE_PLUS)) + 2'(fun_q >= VW'(LIFE_PLUS)) +
               2'(rest_q >= VW'(LIFE_PLUS));
    n_minus  = 2'(food_q <= VW'(LIFE_MINUS)) + 2'(fun_q <= VW'(LIFE_MINUS)) +
               2'(rest_q <= VW'(LIFE_MINUS));
    life_sum = AW'(life_q) + AW'(n_plus);
    life_new = (life_sum <= AW'(n_minus)) ? '0 : life_sum - AW'(n_minus);
    if (life_new > AW'(MAX_VAL)) life_new = AW'(MAX_VAL);

    case (state_q)
      IDLE: begin
        if (tick_pend_q) begin
          enter_decay = 1'b1;
          state_d     = DECAY;
        end else if (req_valid && req_ready) begin
          kind_d  = req_kind;
          state_d = ACTION;
        end
      end
      DECAY: begin
        if (!death_q) begin
          if (food_cnt_q == DW'(FOOD_DIV - 1)) begin
            food_cnt_d = '0;
            food_d     = dec_sat(food_q);
          end else food_cnt_d = food_cnt_q + DW'(1);
          if (fun_cnt_q == DW'(FUN_DIV - 1)) begin
            fun_cnt_d = '0;
            fun_d     = dec_sat(fun_q);
          end else fun_cnt_d = fun_cnt_q + DW'(1);
          if (rest_cnt_q == DW'(REST_DIV - 1)) begin
            rest_cnt_d = '0;
            rest_d     = dec_sat(rest_q);
          end else rest_cnt_d = rest_cnt_q + DW'(1);
        end
        for (int i = 0; i < 4; i++) begin
          if (cd_q[i] != '0) cd_d[i] = cd_q[i] - CDW'(1);
        end
        state_d = death_q ? IDLE : LIFE_ADJ;
      end
      LIFE_ADJ: begin
        life_d  = VW'(life_new);
        death_d = death_q | (life_new == '0);
        state_d = IDLE;
      end
      ACTION: begin
        if (death_q) resp_status_d = ST_DEAD;
        else if (cd_q[kind_q] != '0) resp_status_d = ST_COOL;
        else if (kind_q == K_HEAL && med_q == '0) resp_status_d = ST_NO_MED;
        else begin
          resp_status_d = ST_OK;
          cd_d[kind_q]  = CDW'(COOLDOWN);
          case (kind_q)
            K_PLAY:  fun_d  = sat_add(fun_q, AW'(ACT_STEP));
            K_SLEEP: rest_d = sat_add(rest_q, AW'(ACT_STEP));
            K_EAT:   food_d = sat_add(food_q, AW'(ACT_STEP));
            default: begin
              life_d  = sat_add(life_q, AW'(HEAL_AMT));
              med_dec = 1'b1;
            end
          endcase
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tick_pend_d = tick | (tick_pend_q & ~enter_decay);

    // A coincident add and heal-spend cancel out
    if (med_inc && !med_dec) begin
      if (med_q != MW'(MED_MAX)) med_d = med_q + MW'(1);
    end else if (med_dec && !med_inc) begin
      med_d = med_q - MW'(1);
    end
  end

  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state_q       <= IDLE;
      food_q        <= VW'(INIT_NEED);
      fun_q         <= VW'(INIT_NEED);
      rest_q        <= VW'(INIT_NEED);
      life_q        <= VW'(INIT_LIFE);
      med_q         <= '0;
      food_cnt_q    <= '0;
      fun_cnt_q     <= '0;
      rest_cnt_q    <= '0;
      cd_q          <= '0;
      kind_q        <= '0;
      tick_pend_q   <= 1'b0;
      death_q       <= 1'b0;
      overrun_q     <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
    end else begin
      state_q       <= state_d;
      food_q        <= food_d;
      fun_q         <= fun_d;
      rest_q        <= rest_d;
      life_q        <= life_d;
      med_q         <= med_d;
      food_cnt_q    <= food_cnt_d;
      fun_cnt_q     <= fun_cnt_d;
      rest_cnt_q    <= rest_cnt_d;
      cd_q          <= cd_d;
      kind_q        <= kind_d;
      tick_pend_q   <= tick_pend_d;
      death_q       <= death_d;
      overrun_q     <= overrun_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
    end
  end

endmodule

// File: tb/tb_needs_scheduler.sv
// Scoreboard bench for needs_scheduler: directed ticks/requests with
// hand-computed need/life values; responses checked by a separate monitor.
module tb_needs_scheduler;

  logic       clk;
  logic       btn_reset;
  logic       tick;
  logic       req_valid;
  logic [1:0] req_kind;
  logic       req_ready;
  logic       resp_valid;
  logic [1:0] resp_status;
  logic       med_add;
  logic [6:0] food, fun, rest, life;
  logic [3:0] medicines;
  logic       disease, death, tick_overrun;

  localparam logic [1:0] PLAY = 2'd0, SLEEP = 2'd1, EAT = 2'd2, HEAL = 2'd3;

  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_s;
  int         w;

  needs_scheduler dut (
    .clk          (clk),
    .btn_reset    (btn_reset),
    .tick         (tick),
    .req_valid    (req_valid),
    .req_kind     (req_kind),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_status  (resp_status),
    .med_add      (med_add),
    .food         (food),
    .fun          (fun),
    .rest         (rest),
    .life         (life),
    .medicines    (medicines),
    .disease      (disease),
    .death        (death),
    .tick_overrun (tick_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge clk) begin
    if (resp_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL resp_unexpected: got status %0d, no response expected", resp_status);
      end else begin
        exp_s = exp_q.pop_front();
        if (resp_status !== exp_s) begin
          n_err++;
          $display("FAIL resp_status: got %0d, expected %0d", resp_status, exp_s);
        end
      end
    end
  end

  task automatic do_tick();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic pulse_med();
    med_add = 1'b1;
    @(posedge clk); #1;
    med_add = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_req(input logic [1:0] kind, input logic [1:0] exp, input bit med_in_action);
    int waited;
    waited = 0;
    req_valid = 1'b1;
    req_kind  = kind;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("req_ready", int'(req_ready), 1);
    exp_q.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (med_in_action) med_add = 1'b1;
    @(posedge clk); #1;
    med_add = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    btn_reset = 1'b0;
    tick      = 1'b0;
    req_valid = 1'b0;
    req_kind  = 2'd0;
    med_add   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    btn_reset = 1'b1;
    #1;

    // Reset state
    chk("rst_life", life, 100);
    chk("rst_food", food, 50);
    chk("rst_fun", fun, 50);
    chk("rst_rest", rest, 50);
    chk("rst_med", medicines, 0);
    chk("rst_death", death, 0);
    chk("rst_disease", disease, 0);
    chk("rst_overrun", tick_overrun, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ready", req_ready, 1);

    // 15 idle ticks
    run_ticks(15);
    chk("t15_food", food, 45);
    chk("t15_fun", fun, 47);
    chk("t15_rest", rest, 47);
    chk("t15_life", life, 100);
    chk("t15_disease", disease, 0);

    // Actions and per-kind cooldown
    do_req(EAT, 2'd0, 1'b0);
    chk("eat1_food", food, 50);
    do_req(PLAY, 2'd0, 1'b0);
    chk("play_fun", fun, 52);
    do_req(EAT, 2'd1, 1'b0);
    chk("eat_cool_food", food, 50);
    run_ticks(3);
    chk("t18_food", food, 49);
    chk("t18_fun", fun, 51);
    do_req(EAT, 2'd0, 1'b0);
    chk("eat2_food", food, 54);

    // Food drains to 30 first, then fun and rest follow
    run_ticks(81);
    chk("t99_life", life, 90);
    chk("t99_food", food, 27);
    chk("t99_fun", fun, 31);
    chk("t99_rest", rest, 31);
    run_ticks(1);
    chk("t100_life", life, 87);
    chk("t100_fun", fun, 30);
    chk("t100_rest", rest, 30);
    run_ticks(22);
    chk("t122_life", life, 21);
    chk("t122_disease", disease, 0);
    run_ticks(1);
    chk("t123_life", life, 18);
    chk("t123_disease", disease, 1);

    // Heal and medicines
    do_req(HEAL, 2'd2, 1'b0);
    chk("heal_nomed_life", life, 18);
    pulse_med();
    pulse_med();
    chk("med_two", medicines, 2);
    do_req(HEAL, 2'd0, 1'b0);
    chk("heal_life", life, 38);
    chk("heal_med", medicines, 1);
    run_ticks(6);
    chk("t129_life", life, 20);
    chk("t129_disease", disease, 1);
    do_req(HEAL, 2'd0, 1'b1);
    chk("heal_coinc_life", life, 40);
    chk("heal_coinc_med", medicines, 1);

    // Death
    run_ticks(13);
    chk("t142_life", life, 1);
    chk("t142_death", death, 0);
    run_ticks(1);
    chk("t143_life", life, 0);
    chk("t143_death", death, 1);
    chk("t143_disease", disease, 0);
    chk("t143_food", food, 13);
    run_ticks(1);
    chk("dead_food", food, 13);
    chk("dead_fun", fun, 20);
    chk("dead_rest", rest, 22);
    chk("dead_life", life, 0);
    do_req(PLAY, 2'd3, 1'b0);
    do_req(HEAL, 2'd3, 1'b0);
    pulse_med();
    chk("dead_med", medicines, 1);

    // Reset during ACTION: no response, defaults restored
    req_valid = 1'b1;
    req_kind  = PLAY;
    @(posedge clk); #1;
    req_valid = 1'b0;
    btn_reset = 1'b0;
    #2;
    btn_reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst2_life", life, 100);
    chk("rst2_food", food, 50);
    chk("rst2_fun", fun, 50);
    chk("rst2_rest", rest, 50);
    chk("rst2_med", medicines, 0);
    chk("rst2_death", death, 0);
    chk("rst2_resp_valid", resp_valid, 0);

    // Tick and request in the same cycle: decay pass goes first
    run_ticks(2);
    tick      = 1'b1;
    req_valid = 1'b1;
    req_kind  = EAT;
    #1;
    chk("ready_with_tick", req_ready, 0);
    @(posedge clk); #1;
    tick = 1'b0;
    w = 1;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("collision_wait", w, 4);
    chk("collision_food_pre", food, 49);
    exp_q.push_back(2'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("collision_food_post", food, 54);

    // Back-to-back ticks overrun the pending flag
    chk("overrun_pre", tick_overrun, 0);
    tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("overrun_post", tick_overrun, 1);
    chk("overrun_food", food, 54);
    chk("overrun_fun", fun, 49);
    chk("overrun_rest", rest, 49);

    chk("resp_all_seen", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
